pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Downstream consumer of the branch-source selector in the nonpipelined LEGv8 core.
- Owns the architectural PC and sequences each instruction through a fetch handshake with instruction memory and an execute window.
- When the execute window ends, selects the next PC from the 2-bit branch source: sequential, PC-relative, or register target.
- Also provides the link value for BL and a retired-instruction counter.

Parameters:
- ADDR_WIDTH, 64, width of PC and all address/target buses.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- branch_src  input  2  next-PC select: 00 = PC+4, 01 = PC-relative, 10 = register target, 11 = reserved (treated as 00).
- imm_offset  input  ADDR_WIDTH  sign-extended word offset from branch/CB decode, not yet shifted.
- reg_target  input  ADDR_WIDTH  register value for BR.
- instr_done  input  1  one-cycle pulse: execute of the current instruction is complete and branch_src is valid.
- halt  input  1  sampled with instr_done; stops sequencing after this instruction.
- fetch_ack  input  1  instruction memory has returned the word at fetch_addr.
- fetch_req  output  1  request fetch of fetch_addr.
- fetch_addr  output  ADDR_WIDTH  equals pc.
- pc  output  ADDR_WIDTH  architectural PC of the current instruction.
- pc_plus4  output  ADDR_WIDTH  pc+4, combinational, for the BL link write.
- instr_valid  output  1  high while in EXEC.
- halted  output  1  high in HALTED.
- misaligned  output  1  sticky; set when a register target has bits [1:0] != 0.
- instret  output  64  count of instructions completed.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = START
  - pc = RESET_PC
  - fetch_req = 0, instr_valid = 0, halted = 0, misaligned = 0
  - instret = 0
- States and transitions:
  - START -> FETCH unconditionally on the first clock edge after reset deasserts.
  - FETCH: fetch_req = 1. Transition to EXEC on the edge where fetch_ack = 1; otherwise hold. Fetch latency is therefore ≥ 1 cycle.
  - EXEC: instr_valid = 1. On the edge where instr_done = 1:
    - pc <= next_pc
    - instret <= instret + 1
    - go to HALTED if halt = 1, else go to FETCH.
  - HALTED: terminal. pc and instret frozen; only reset leaves it.
- Outputs:
  - fetch_req and instr_valid are decoded from state only, with no combinational path from inputs.
  - fetch_addr = pc.
- next_pc, all arithmetic modulo 2^ADDR_WIDTH with wrap-around and no fault:
  - 00/11: pc + 4
  - 01: pc + (imm_offset << 2); bits shifted out are discarded.
  - 10: {reg_target[ADDR_WIDTH-1:2], 2'b00}. If reg_target[1:0] != 0, set misaligned (sticky until reset).
- Ignored inputs:
  - fetch_ack outside FETCH.
  - instr_done outside EXEC.
  - halt without instr_done.
- A halted instruction still updates pc, counts in instret, and may set misaligned.
- instret wraps from 2^64-1 to 0.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately. The outstanding request is dropped and no retire is counted.
- Minimum instruction period is 2 cycles (FETCH with immediate ack, then EXEC with immediate done).

Test Plan:
- Reset with RESET_PC = 0x400 -> pc = 0x400, fetch_req = 0 during reset; fetch_req = 1 one edge after deassert; ack after 3 cycles -> instr_valid = 1.
- Three instructions with branch_src = 00, ack and done immediate -> pc sequence 0x400, 0x404, 0x408; instret = 3; fetch_req/instr_valid alternate every cycle.
- pc = 0x1000, branch_src = 01, imm_offset = 0xFFFF_FFFF_FFFF_FFFE -> next pc = 0x0FF8. Then imm_offset = 4 -> pc = 0x1008. pc = 0xFFFF_FFFF_FFFF_FFFC with 00 -> pc = 0 (wrap).
- branch_src = 10, reg_target = 0x2003 -> pc = 0x2000, misaligned = 1 and stays 1 after a later aligned BR; branch_src = 11 -> pc + 4.
- halt = 1 with instr_done at pc = 0x40 -> pc = 0x44, halted = 1, instret incremented; fetch_req stays 0; further ack/done pulses change nothing.
- Reset pulsed in EXEC before instr_done -> pc = RESET_PC, instret = 0, misaligned = 0, state START; a stray fetch_ack during EXEC produces no state change.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC of the nonpipelined LEGv8 core.
// Steps each instruction through a fetch handshake and an execute window,
// picks the next PC from the branch source at retire, and counts retires.
module pc_sequencer #(
    parameter int              ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            branch_src,
    input  logic [ADDR_WIDTH-1:0] imm_offset,
    input  logic [ADDR_WIDTH-1:0] reg_target,
    input  logic                  instr_done,
    input  logic                  halt,
    input  logic                  fetch_ack,
    output logic                  fetch_req,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  instr_valid,
    output logic                  halted,
    output logic                  misaligned,
    output logic [63:0]           instret
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    misaligned_q, misaligned_d;
    logic [63:0]             instret_q, instret_d;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic [ADDR_WIDTH-1:0]   rel_target;
    logic                    retire;

    // Branch offset is a word count; shift to bytes, dropping the top bits.
    assign rel_target = pc_q + {imm_offset[ADDR_WIDTH-3:0], 2'b00};
    assign pc_plus4   = pc_q + ADDR_WIDTH'(4);
    assign retire     = (state_q == EXEC) && instr_done;

    // Next-PC select; reserved encoding 11 falls back to sequential.
    always_comb begin
        next_pc = pc_plus4;
        case (branch_src)
            2'b01:   next_pc = rel_target;
            2'b10:   next_pc = {reg_target[ADDR_WIDTH-1:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // Sequencing FSM plus the PC, retire counter and sticky misalignment flag.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instret_d    = instret_q;
        misaligned_d = misaligned_q;
        case (state_q)
            START:  state_d = FETCH;
            FETCH:  if (fetch_ack) state_d = EXEC;
            EXEC: begin
                if (instr_done) begin
                    state_d = halt ? HALTED : FETCH;
                end
            end
            default: state_d = HALTED;
        endcase
        if (retire) begin
            pc_d      = next_pc;
            instret_d = instret_q + 64'd1;
            if (branch_src == 2'b10 && reg_target[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end
    end

    // State registers; reset aborts any in-flight fetch or execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= START;
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
            instret_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            instret_q    <= instret_d;
        end
    end

    // Handshake outputs decode from state only, so no input reaches them.
    assign fetch_req   = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALTED);
    assign fetch_addr  = pc_q;
    assign pc          = pc_q;
    assign misaligned  = misaligned_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of retire vectors plus hand-written
// reset, halt and abort sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  branch_src;
    logic [63:0] imm_offset, reg_target;
    logic        instr_done, halt, fetch_ack;
    logic        fetch_req, instr_valid, halted, misaligned;
    logic [63:0] fetch_addr, pc, pc_plus4, instret;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.ADDR_WIDTH(64), .RESET_PC(64'h400)) dut (
        .clk(clk), .reset(reset), .branch_src(branch_src),
        .imm_offset(imm_offset), .reg_target(reg_target),
        .instr_done(instr_done), .halt(halt), .fetch_ack(fetch_ack),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .pc(pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .halted(halted),
        .misaligned(misaligned), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  bsrc;
        logic [63:0] imm;
        logic [63:0] rt;
        logic        hlt;
        logic [63:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One instruction: wait for fetch, ack after ack_delay cycles, retire.
    task automatic run_instr(input vec_t v, input int ack_delay, input logic [63:0] exp_ret);
        logic [63:0] pc_before;
        for (int k = 0; k < 20 && !fetch_req; k++) @(negedge clk);
        chk("fetch_wait", {63'd0, fetch_req}, 64'd1);
        for (int k = 0; k < ack_delay; k++) begin
            instr_done = 1'b1;   // must be ignored outside EXEC
            @(negedge clk);
            instr_done = 1'b0;
            chk("hold_fetch", {62'd0, fetch_req, instr_valid}, 64'd2);
            chk("no_retire_in_fetch", instret, exp_ret - 64'd1);
        end
        pc_before = pc;
        chk("fetch_addr", fetch_addr, pc);
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("exec_state", {62'd0, fetch_req, instr_valid}, 64'd1);
        chk("pc_plus4", pc_plus4, pc_before + 64'd4);
        branch_src = v.bsrc; imm_offset = v.imm; reg_target = v.rt; halt = v.hlt;
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0; halt = 1'b0; branch_src = 2'b00;
        chk("next_pc", pc, v.exp_pc);
        chk("instret", instret, exp_ret);
        chk("misaligned", {63'd0, misaligned}, {63'd0, v.exp_mis});
        chk("halted", {63'd0, halted}, {63'd0, v.hlt});
        chk("fetch_after", {63'd0, fetch_req}, {63'd0, ~v.hlt});
    endtask

    initial begin
        vec_t tmp;
        vecs[0]  = '{2'b00, 64'd0, 64'd0, 1'b0, 64'h404, 1'b0};
        vecs[1]  = '{2'b00, 64'd0, 64'd0, 1'b0, 64'h408, 1'b0};
        vecs[2]  = '{2'b10, 64'd0, 64'h1000, 1'b0, 64'h1000, 1'b0};
        vecs[3]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 64'h0FF8, 1'b0};
        vecs[4]  = '{2'b01, 64'd4, 64'd0, 1'b0, 64'h1008, 1'b0};
        vecs[5]  = '{2'b10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[6]  = '{2'b00, 64'd0, 64'd0, 1'b0, 64'h0, 1'b0};
        vecs[7]  = '{2'b10, 64'd0, 64'h2003, 1'b0, 64'h2000, 1'b1};
        vecs[8]  = '{2'b10, 64'd0, 64'h3000, 1'b0, 64'h3000, 1'b1};
        vecs[9]  = '{2'b11, 64'h55, 64'h7777, 1'b0, 64'h3004, 1'b1};
        vecs[10] = '{2'b10, 64'd0, 64'h40, 1'b0, 64'h40, 1'b1};
        vecs[11] = '{2'b00, 64'd0, 64'd0, 1'b1, 64'h44, 1'b1};

        reset = 1'b1; branch_src = 2'b00; imm_offset = '0; reg_target = '0;
        instr_done = 1'b0; halt = 1'b0; fetch_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 64'h400);
        chk("rst_outs", {60'd0, fetch_req, instr_valid, halted, misaligned}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("start_to_fetch", {63'd0, fetch_req}, 64'd1);

        // First instruction acks after 3 cycles, the rest immediately.
        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i], (i == 0) ? 3 : 0, 64'(i + 1));
        end

        // Halted is terminal: pulses of ack/done change nothing.
        for (int k = 0; k < 3; k++) begin
            fetch_ack = 1'b1; instr_done = 1'b1; branch_src = 2'b10; reg_target = 64'h9001;
            @(negedge clk);
        end
        fetch_ack = 1'b0; instr_done = 1'b0; branch_src = 2'b00;
        chk("halt_pc", pc, 64'h44);
        chk("halt_instret", instret, 64'd12);
        chk("halt_flags", {61'd0, halted, fetch_req, instr_valid}, 64'd4);

        // Reset aborts mid-EXEC; stray ack in EXEC is ignored.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tmp = '{2'b10, 64'd0, 64'h503, 1'b0, 64'h500, 1'b1};
        run_instr(tmp, 0, 64'd1);
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("exec_entered", {63'd0, instr_valid}, 64'd1);
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("stray_ack_state", {62'd0, fetch_req, instr_valid}, 64'd1);
        chk("stray_ack_pc", pc, 64'h500);
        #2 reset = 1'b1;
        #1;
        chk("abort_pc", pc, 64'h400);
        chk("abort_instret", instret, 64'd0);
        chk("abort_flags", {60'd0, fetch_req, instr_valid, halted, misaligned}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_refetch", {62'd0, fetch_req, instr_valid}, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
